// File: rtl/idct_pixel_out.sv
// rtl/idct_pixel_out.sv - IDCT output stage: capture 8x8 block, round/level-shift/clamp, stream pixels in raster order
//
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   block_done       single-cycle pulse, block_in valid in that cycle
//   block_in         signed Q(IN_WIDTH-FRAC_BITS).FRAC_BITS samples [row][col]
//   pix_valid/ready  pixel handshake; transfer when both high
//   pix_data         8-bit unsigned pixel
//   pix_row/pix_col  raster position of pix_data
//   pix_last         high with pix_valid on the final pixel of the block
//   busy             high while streaming
//   drop_err         sticky, set when a block_done arrives that cannot be taken
//   sat_count        (PIXOUT_SAT_COUNT_EN only) clamped pixels transferred in current block
//
// Optional feature macro: PIXOUT_SAT_COUNT_EN
module idct_pixel_out #(
    parameter int BLOCK_SIZE = 8,
    parameter int IN_WIDTH   = 63,
    parameter int FRAC_BITS  = 32,
    localparam int CW        = $clog2(BLOCK_SIZE)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       block_done,
    input  logic signed [IN_WIDTH-1:0] block_in [BLOCK_SIZE][BLOCK_SIZE],
    output logic                       pix_valid,
    input  logic                       pix_ready,
    output logic [7:0]                 pix_data,
    output logic [CW-1:0]              pix_row,
    output logic [CW-1:0]              pix_col,
    output logic                       pix_last,
    output logic                       busy,
`ifdef PIXOUT_SAT_COUNT_EN
    output logic [6:0]                 sat_count,
`endif
    output logic                       drop_err
);

    typedef enum logic {IDLE, STREAM} state_t;

    localparam logic [CW-1:0]            LAST_IDX = CW'(BLOCK_SIZE - 1);
    localparam logic signed [IN_WIDTH:0] HALF     = (IN_WIDTH + 1)'(1) <<< (FRAC_BITS - 1);
    localparam logic signed [IN_WIDTH:0] LEVEL    = (IN_WIDTH + 1)'(128);
    localparam logic signed [IN_WIDTH:0] PIX_MAX  = (IN_WIDTH + 1)'(255);

    state_t state, state_nxt;

    logic signed [IN_WIDTH-1:0] pix_buf [BLOCK_SIZE][BLOCK_SIZE];
    logic [CW-1:0]              row, col;
    logic                       xfer, at_last, capture, drop, clamped;
    logic signed [IN_WIDTH:0]   sum, rnd, lvl;
    logic [7:0]                 conv;

    assign at_last = (row == LAST_IDX) && (col == LAST_IDX);
    assign xfer    = (state == STREAM) && pix_ready;
    // A new block fits only when the buffer is free or is being emptied this cycle.
    assign capture = block_done && ((state == IDLE) || (xfer && at_last));
    assign drop    = block_done && !capture;

    // One extra bit of headroom so the rounding add cannot overflow.
    always_comb begin
        sum     = {pix_buf[row][col][IN_WIDTH-1], pix_buf[row][col]} + HALF;
        rnd     = sum >>> FRAC_BITS;
        lvl     = rnd + LEVEL;
        clamped = 1'b0;
        conv    = lvl[7:0];
        if (lvl[IN_WIDTH]) begin
            conv    = 8'h00;
            clamped = 1'b1;
        end else if (lvl > PIX_MAX) begin
            conv    = 8'hFF;
            clamped = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (block_done) state_nxt = STREAM;
            STREAM:  if (xfer && at_last && !block_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row      <= '0;
            col      <= '0;
            drop_err <= 1'b0;
        end else begin
            if (capture) begin
                row <= '0;
                col <= '0;
            end else if (xfer) begin
                col <= (col == LAST_IDX) ? '0 : col + 1'b1;
                if (col == LAST_IDX) begin
                    row <= (row == LAST_IDX) ? '0 : row + 1'b1;
                end
            end
            if (drop) begin
                drop_err <= 1'b1;
            end
        end
    end

    // Sample storage needs no reset; contents are only read while streaming.
    always_ff @(posedge clk) begin
        if (capture) begin
            pix_buf <= block_in;
        end
    end

    assign pix_valid = (state == STREAM);
    assign busy      = (state == STREAM);
    assign pix_row   = row;
    assign pix_col   = col;
    assign pix_last  = pix_valid && at_last;
    assign pix_data  = pix_valid ? conv : 8'h00;

`ifdef PIXOUT_SAT_COUNT_EN
    logic [6:0] sat_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sat_q <= '0;
        end else if (capture) begin
            sat_q <= '0;
        end else if (xfer && clamped) begin
            sat_q <= sat_q + 1'b1;
        end
    end

    assign sat_count = sat_q;
`else
    logic unused_clamped;
    assign unused_clamped = clamped;
`endif

endmodule
